// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter: zero-latency AXI4 stage capping outstanding read/write bursts,
// with per-direction response watchdogs and stray-response detection.
module axi_txn_limiter #(
   parameter int MAX_RD  = 8,
   parameter int MAX_WR  = 8,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 8,
   parameter int ADDR_W  = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [3:0]        s_axi_arid,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]        s_axi_arlen,
   input  logic [2:0]        s_axi_arsize,
   input  logic [1:0]        s_axi_arburst,
   input  logic              s_axi_arlock,
   input  logic [3:0]        s_axi_arcache,
   input  logic [2:0]        s_axi_arprot,
   input  logic [3:0]        s_axi_arqos,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   input  logic [3:0]        s_axi_awid,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic              s_axi_awlock,
   input  logic [3:0]        s_axi_awcache,
   input  logic [2:0]        s_axi_awprot,
   input  logic [3:0]        s_axi_awqos,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [63:0]       s_axi_wdata,
   input  logic [7:0]        s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [3:0]        s_axi_rid,
   output logic [63:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rlast,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [3:0]        s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   output logic [3:0]        m_axi_arid,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arlock,
   output logic [3:0]        m_axi_arcache,
   output logic [2:0]        m_axi_arprot,
   output logic [3:0]        m_axi_arqos,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   output logic [3:0]        m_axi_awid,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic [1:0]        m_axi_awburst,
   output logic              m_axi_awlock,
   output logic [3:0]        m_axi_awcache,
   output logic [2:0]        m_axi_awprot,
   output logic [3:0]        m_axi_awqos,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [63:0]       m_axi_wdata,
   output logic [7:0]        m_axi_wstrb,
   output logic              m_axi_wlast,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [3:0]        m_axi_rid,
   input  logic [63:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   input  logic [3:0]        m_axi_bid,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [CNT_W-1:0]  rd_outstanding,
   output logic [CNT_W-1:0]  wr_outstanding,
   output logic              rd_timeout,
   output logic              wr_timeout,
   output logic              stray_resp,
   input  logic              clr_status
);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [TW-1:0]    rd_tmr_q, rd_tmr_d, wr_tmr_q, wr_tmr_d;
   logic             rd_to_q, rd_to_d, wr_to_q, wr_to_d, stray_q, stray_d;
   logic             rd_ok, wr_ok, ar_hs, aw_hs, r_beat, r_done, b_done;
   logic             rd_stray, wr_stray, rd_idle, wr_idle;

   assign m_axi_arid    = s_axi_arid;
   assign m_axi_araddr  = s_axi_araddr;
   assign m_axi_arlen   = s_axi_arlen;
   assign m_axi_arsize  = s_axi_arsize;
   assign m_axi_arburst = s_axi_arburst;
   assign m_axi_arlock  = s_axi_arlock;
   assign m_axi_arcache = s_axi_arcache;
   assign m_axi_arprot  = s_axi_arprot;
   assign m_axi_arqos   = s_axi_arqos;
   assign m_axi_arvalid = s_axi_arvalid & rd_ok;
   assign s_axi_arready = m_axi_arready & rd_ok;
   assign m_axi_awid    = s_axi_awid;
   assign m_axi_awaddr  = s_axi_awaddr;
   assign m_axi_awlen   = s_axi_awlen;
   assign m_axi_awsize  = s_axi_awsize;
   assign m_axi_awburst = s_axi_awburst;
   assign m_axi_awlock  = s_axi_awlock;
   assign m_axi_awcache = s_axi_awcache;
   assign m_axi_awprot  = s_axi_awprot;
   assign m_axi_awqos   = s_axi_awqos;
   assign m_axi_awvalid = s_axi_awvalid & wr_ok;
   assign s_axi_awready = m_axi_awready & wr_ok;
   assign m_axi_wdata   = s_axi_wdata;
   assign m_axi_wstrb   = s_axi_wstrb;
   assign m_axi_wlast   = s_axi_wlast;
   assign m_axi_wvalid  = s_axi_wvalid;
   assign s_axi_wready  = m_axi_wready;
   assign s_axi_rid     = m_axi_rid;
   assign s_axi_rdata   = m_axi_rdata;
   assign s_axi_rresp   = m_axi_rresp;
   assign s_axi_rlast   = m_axi_rlast;
   assign s_axi_rvalid  = m_axi_rvalid;
   assign m_axi_rready  = s_axi_rready;
   assign s_axi_bid     = m_axi_bid;
   assign s_axi_bresp   = m_axi_bresp;
   assign s_axi_bvalid  = m_axi_bvalid;
   assign m_axi_bready  = s_axi_bready;

   assign rd_outstanding = rd_cnt_q;
   assign wr_outstanding = wr_cnt_q;
   assign rd_timeout     = rd_to_q;
   assign wr_timeout     = wr_to_q;
   assign stray_resp     = stray_q;

   // Gating uses registered counts only, so an offered AR/AW stays offered until it handshakes.
   always_comb begin
      rd_ok    = rd_cnt_q < CNT_W'(MAX_RD);
      wr_ok    = wr_cnt_q < CNT_W'(MAX_WR);
      ar_hs    = m_axi_arvalid & m_axi_arready;
      aw_hs    = m_axi_awvalid & m_axi_awready;
      r_beat   = m_axi_rvalid & m_axi_rready;
      r_done   = r_beat & m_axi_rlast;
      b_done   = m_axi_bvalid & m_axi_bready;
      rd_stray = r_done & ~ar_hs & (rd_cnt_q == '0);
      wr_stray = b_done & ~aw_hs & (wr_cnt_q == '0);
      rd_cnt_d = rd_stray ? '0 : rd_cnt_q + CNT_W'(ar_hs) - CNT_W'(r_done);
      wr_cnt_d = wr_stray ? '0 : wr_cnt_q + CNT_W'(aw_hs) - CNT_W'(b_done);
      rd_idle  = (rd_cnt_q != '0) & ~r_beat;
      wr_idle  = (wr_cnt_q != '0) & ~b_done;
      rd_tmr_d = !rd_idle ? '0 : (rd_tmr_q == TW'(TIMEOUT)) ? rd_tmr_q : rd_tmr_q + TW'(1);
      wr_tmr_d = !wr_idle ? '0 : (wr_tmr_q == TW'(TIMEOUT)) ? wr_tmr_q : wr_tmr_q + TW'(1);
      rd_to_d  = (rd_idle & (rd_tmr_q == TW'(TIMEOUT - 1))) | (rd_to_q & ~clr_status);
      wr_to_d  = (wr_idle & (wr_tmr_q == TW'(TIMEOUT - 1))) | (wr_to_q & ~clr_status);
      stray_d  = rd_stray | wr_stray | (stray_q & ~clr_status);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         rd_tmr_q <= '0;
         wr_tmr_q <= '0;
         rd_to_q  <= 1'b0;
         wr_to_q  <= 1'b0;
         stray_q  <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         rd_tmr_q <= rd_tmr_d;
         wr_tmr_q <= wr_tmr_d;
         rd_to_q  <= rd_to_d;
         wr_to_q  <= wr_to_d;
         stray_q  <= stray_d;
      end
   end
endmodule

// File: tb/tb_axi_txn_limiter.sv
// tb_axi_txn_limiter: directed stimulus against a transaction-level model of
// outstanding bursts, idle time and sticky flags, checked every cycle.
module tb_axi_txn_limiter;
   localparam int MAX_RD = 2, MAX_WR = 3, TIMEOUT = 16, CNT_W = 8, AW = 32;

   logic aclk = 1'b0, aresetn = 1'b0, clr_status = 1'b0;
   logic [3:0] s_arid, s_awid, m_arid, m_awid, s_rid, s_bid, m_rid, m_bid;
   logic [AW-1:0] s_araddr, s_awaddr, m_araddr, m_awaddr;
   logic [7:0] s_arlen, s_awlen, m_arlen, m_awlen, s_wstrb, m_wstrb;
   logic [2:0] s_arsize, s_awsize, m_arsize, m_awsize, s_arprot, s_awprot, m_arprot, m_awprot;
   logic [1:0] s_arburst, s_awburst, m_arburst, m_awburst, s_rresp, m_rresp, s_bresp, m_bresp;
   logic s_arlock, s_awlock, m_arlock, m_awlock;
   logic [3:0] s_arcache, s_awcache, m_arcache, m_awcache, s_arqos, s_awqos, m_arqos, m_awqos;
   logic s_arvalid, s_arready, m_arvalid, m_arready, s_awvalid, s_awready, m_awvalid, m_awready;
   logic [63:0] s_wdata, m_wdata, s_rdata, m_rdata;
   logic s_wlast, m_wlast, s_wvalid, m_wvalid, s_wready, m_wready;
   logic s_rlast, m_rlast, s_rvalid, m_rvalid, s_rready, m_rready;
   logic s_bvalid, m_bvalid, s_bready, m_bready;
   logic [CNT_W-1:0] rd_outstanding, wr_outstanding;
   logic rd_timeout, wr_timeout, stray_resp;

   axi_txn_limiter #(.MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .ADDR_W(AW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
      .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock), .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot),
      .s_axi_arqos(s_arqos), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
      .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
      .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock), .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot),
      .s_axi_awqos(s_awqos), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
      .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid),
      .s_axi_wready(s_wready),
      .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
      .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
      .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
      .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
      .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
      .m_axi_arqos(m_arqos), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
      .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
      .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot),
      .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
      .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid),
      .m_axi_wready(m_wready),
      .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
      .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
      .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
      .rd_timeout(rd_timeout), .wr_timeout(wr_timeout), .stray_resp(stray_resp), .clr_status(clr_status)
   );

   always #5 aclk = ~aclk;

   int ntests = 0, nfail = 0;
   bit chk_en = 1'b0;

   // Model: outstanding burst counts, cycles idle since the last response, sticky flags.
   int  mod_rd = 0, mod_wr = 0, idle_rd = 0, idle_wr = 0;
   bit  mod_rto = 0, mod_wto = 0, mod_stray = 0;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   always @(posedge aclk) begin
      automatic bit ar = s_arvalid && m_arready && (mod_rd < MAX_RD);
      automatic bit aw = s_awvalid && m_awready && (mod_wr < MAX_WR);
      automatic bit rb = m_rvalid && s_rready;
      automatic bit rl = rb && m_rlast;
      automatic bit bd = m_bvalid && s_bready;
      automatic int nrd = mod_rd + int'(ar) - int'(rl);
      automatic int nwr = mod_wr + int'(aw) - int'(bd);
      automatic int nir = (mod_rd == 0 || rb) ? 0 : idle_rd + 1;
      automatic int niw = (mod_wr == 0 || bd) ? 0 : idle_wr + 1;
      if (!aresetn) begin
         mod_rd <= 0; mod_wr <= 0; idle_rd <= 0; idle_wr <= 0;
         mod_rto <= 0; mod_wto <= 0; mod_stray <= 0;
      end else begin
         mod_rd    <= nrd < 0 ? 0 : nrd;
         mod_wr    <= nwr < 0 ? 0 : nwr;
         idle_rd   <= nir;
         idle_wr   <= niw;
         mod_rto   <= (nir == TIMEOUT) || (mod_rto && !clr_status);
         mod_wto   <= (niw == TIMEOUT) || (mod_wto && !clr_status);
         mod_stray <= (nrd < 0) || (nwr < 0) || (mod_stray && !clr_status);
      end
   end

   always @(negedge aclk) if (chk_en) begin
      chk("m_arvalid", m_arvalid, s_arvalid && (mod_rd < MAX_RD));
      chk("s_arready", s_arready, m_arready && (mod_rd < MAX_RD));
      chk("m_awvalid", m_awvalid, s_awvalid && (mod_wr < MAX_WR));
      chk("s_awready", s_awready, m_awready && (mod_wr < MAX_WR));
      chk("rd_outstanding", rd_outstanding, mod_rd);
      chk("wr_outstanding", wr_outstanding, mod_wr);
      chk("rd_timeout", rd_timeout, mod_rto);
      chk("wr_timeout", wr_timeout, mod_wto);
      chk("stray_resp", stray_resp, mod_stray);
      chk("ar_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos},
                        {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos});
      chk("aw_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos},
                        {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos});
      chk("w_chan", {m_wdata, m_wstrb, m_wlast, m_wvalid, s_wready}, {s_wdata, s_wstrb, s_wlast, s_wvalid, m_wready});
      chk("r_chan", {s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, m_rready}, {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, s_rready});
      chk("b_chan", {s_bid, s_bresp, s_bvalid, m_bready}, {m_bid, m_bresp, m_bvalid, s_bready});
   end

   task automatic tick(); @(posedge aclk); #1; endtask

   task automatic quiet();
      {s_arvalid, s_awvalid, s_wvalid, m_rvalid, m_bvalid, m_rlast, clr_status} = '0;
      {m_arready, m_awready, m_wready, s_rready, s_bready} = '1;
   endtask

   task automatic randomize_all();
      {s_arid, s_awid, m_rid, m_bid} = $urandom;
      s_araddr = $urandom; s_awaddr = $urandom;
      s_arlen = 8'($urandom_range(0, 255)); s_awlen = 8'($urandom_range(0, 255));
      {s_arsize, s_awsize, s_arprot, s_awprot, s_arburst, s_awburst, s_arlock, s_awlock} = $urandom;
      {s_arcache, s_awcache, s_arqos, s_awqos} = $urandom;
      s_wdata = {$urandom, $urandom}; m_rdata = {$urandom, $urandom};
      {s_wstrb, s_wlast, m_rresp, m_bresp} = $urandom;
      {s_arvalid, s_awvalid, s_wvalid, m_rvalid, m_bvalid, m_rlast} = $urandom;
      {m_arready, m_awready, m_wready, s_rready, s_bready} = $urandom;
   endtask

   initial begin
      randomize_all();
      quiet();
      repeat (2) tick();
      chk_en = 1'b1;
      tick();
      aresetn = 1'b1;
      @(negedge aclk);
      chk("reset rd_outstanding", rd_outstanding, 0);
      chk("reset wr_outstanding", wr_outstanding, 0);
      chk("reset flags", {rd_timeout, wr_timeout, stray_resp}, 3'b000);
      tick();
      // 1: read cap at MAX_RD=2, released by an R-last
      s_arvalid = 1'b1; s_araddr = 32'h1000; tick();
      s_araddr = 32'h2000; tick();
      s_araddr = 32'h3000;
      @(negedge aclk);
      chk("cap s_arready", s_arready, 1'b0);
      chk("cap m_arvalid", m_arvalid, 1'b0);
      chk("cap rd_outstanding", rd_outstanding, 2);
      tick();
      m_rvalid = 1'b1; m_rlast = 1'b1; tick();
      m_rvalid = 1'b0;
      @(negedge aclk);
      chk("release s_arready", s_arready, 1'b1);
      chk("release rd_outstanding", rd_outstanding, 1);
      tick();
      s_arvalid = 1'b0;
      @(negedge aclk);
      chk("third AR rd_outstanding", rd_outstanding, 2);
      // 2: AR handshake and R-last together at count 1
      tick();
      m_rvalid = 1'b1; tick();
      s_arvalid = 1'b1; tick();
      s_arvalid = 1'b0; m_rvalid = 1'b0;
      @(negedge aclk);
      chk("ar+rlast rd_outstanding", rd_outstanding, 1);
      chk("ar+rlast flags", {rd_timeout, wr_timeout, stray_resp}, 3'b000);
      tick();
      m_rvalid = 1'b1; tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      @(negedge aclk);
      chk("drain rd_outstanding", rd_outstanding, 0);
      // 3: stray B, clear, then set-wins-over-clear
      tick();
      m_bvalid = 1'b1; tick();
      m_bvalid = 1'b0;
      @(negedge aclk);
      chk("stray set", stray_resp, 1'b1);
      chk("stray wr_outstanding", wr_outstanding, 0);
      tick();
      clr_status = 1'b1; tick();
      clr_status = 1'b0;
      @(negedge aclk);
      chk("stray cleared", stray_resp, 1'b0);
      tick();
      m_bvalid = 1'b1; clr_status = 1'b1; tick();
      m_bvalid = 1'b0; clr_status = 1'b0;
      @(negedge aclk);
      chk("set beats clear", stray_resp, 1'b1);
      tick();
      clr_status = 1'b1; tick();
      clr_status = 1'b0;
      // 4: write watchdog, TIMEOUT=16
      s_awvalid = 1'b1; tick();
      s_awvalid = 1'b0;
      repeat (15) tick();
      @(negedge aclk);
      chk("wto before 16", wr_timeout, 1'b0);
      tick();
      @(negedge aclk);
      chk("wto at 16", wr_timeout, 1'b1);
      tick();
      m_bvalid = 1'b1; tick();
      m_bvalid = 1'b0;
      @(negedge aclk);
      chk("wto after B wr_outstanding", wr_outstanding, 0);
      chk("wto sticky", wr_timeout, 1'b1);
      chk("no stray on B", stray_resp, 1'b0);
      tick();
      clr_status = 1'b1; tick();
      clr_status = 1'b0;
      @(negedge aclk);
      chk("wto cleared", wr_timeout, 1'b0);
      // 5: random payloads and handshakes
      for (int i = 0; i < 40; i++) begin
         tick();
         randomize_all();
      end
      tick();
      quiet();
      // 6: reset with reads and writes outstanding plus a sticky flag
      aresetn = 1'b0; tick();
      aresetn = 1'b1;
      m_bvalid = 1'b1; tick();
      m_bvalid = 1'b0; s_arvalid = 1'b1; s_awvalid = 1'b1;
      repeat (3) tick();
      s_arvalid = 1'b0; s_awvalid = 1'b0;
      @(negedge aclk);
      chk("pre-reset rd_outstanding", rd_outstanding, 2);
      chk("pre-reset wr_outstanding", wr_outstanding, 3);
      chk("pre-reset stray", stray_resp, 1'b1);
      tick();
      aresetn = 1'b0; tick();
      @(negedge aclk);
      chk("mid-burst reset counts", {rd_outstanding, wr_outstanding}, 16'h0);
      chk("mid-burst reset flags", {rd_timeout, wr_timeout, stray_resp}, 3'b000);
      aresetn = 1'b1;
      repeat (2) tick();
      @(negedge aclk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
